alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Built-in self-test sequencer that drives the processor ALU's operand/opcode inputs (a, b, 4-bit aluOp) and consumes its 32-bit result.
- Sweeps every supported ALU operation with corner and pseudo-random operands, compacts results into a MISR signature, and flags pass/fail against a characterised golden value.
- Sits beside the ALU, muxed in ahead of the datapath operands during test mode.

Parameters:
- N_VECTORS, 64, vectors per operation; must be >= 4.
- SEED_A, 32'hACE1_2345, operand-A LFSR seed; nonzero.
- SEED_B, 32'h1357_9BDF, operand-B LFSR seed; nonzero.
- GOLDEN_SIG, 32'h0000_0000, expected final MISR value, set after characterisation.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- a_out  out  32  operand A to ALU.
- b_out  out  32  operand B to ALU.
- aluOp_out  out  4  operation code to ALU.
- result_in  in  32  ALU result, combinational from a_out/b_out/aluOp_out.
- busy  out  1  high in SEED, RUN, CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1; 1 = signature matched.
- signature  out  32  current MISR value.

Behaviour:
- Reset: state IDLE; all outputs 0; LFSRs, MISR, counters cleared. Reset in any state overrides everything, including mid-RUN.
- Op table, 10 entries, in this order: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1101 sra.
- IDLE -> SEED when start=1.
- SEED, 1 cycle:
  - LFSR_A=SEED_A, LFSR_B=SEED_B, MISR=0, op_idx=0, vec_idx=0.
  - Load output registers with vector 0 of op 0.
  - -> RUN.
- RUN: one vector per cycle. Each edge:
  - MISR <= {MISR[30:0], MISR[31]^MISR[21]^MISR[1]^MISR[0]} ^ result_in.
  - Both LFSRs advance: Galois, poly 32'h8020_0003, shift right, XOR poly when the shifted-out bit is 1.
  - Output registers load the next vector.
- Vector selection by vec_idx:
  - 0: (0, 0)
  - 1: (FFFF_FFFF, 0000_0001)
  - 2: (8000_0000, 0000_001F)
  - 3: (7FFF_FFFF, 8000_0000)
  - >= 4: (LFSR_A, LFSR_B), values taken after the current edge's advance.
- LFSRs run continuously across ops; they are never reseeded within a run.
- vec_idx wraps to 0 at N_VECTORS-1 and op_idx increments.
- Edge absorbing op 9 / vector N_VECTORS-1 -> CHECK.
- CHECK, 1 cycle: a_out/b_out/aluOp_out <= 0; pass <= (MISR == GOLDEN_SIG); -> DONE.
- DONE: done=1, pass and signature held. start=1 -> SEED, clearing done and pass. start ignored while busy.
- Latency: start sampled at edge E0 gives done=1 after edge E(2 + 10*N_VECTORS).
- signature tracks MISR live.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU opcode constants (shared with the ALU);
  - the 10-entry op table;
  - the corner operand constants;
  - the LFSR and MISR polynomials;
  - the FSM state enum.
- One natural sub-module, lfsr32 (seed load, advance enable), instantiated twice.
- MISR stays inline.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0, busy=0, done=0; start held high during rst is ignored.
- Golden run: N_VECTORS=4, bench ALU model plus software MISR/LFSR mirror, GOLDEN_SIG set to mirror value, start pulse at E0 -> done rises after E42, pass=1, signature equals mirror value.
- Sequencing: N_VECTORS=4 -> aluOp_out sequence 0,0,0,0,1,1,1,1,...,D,D,D,D (40 cycles). First RUN cycle shows a_out=0, b_out=0; second shows FFFF_FFFF/0000_0001.
- Fault detection: bench ALU flips result bit 0 for xor only -> signature differs from golden, pass=0, done=1.
- Reset mid-run: rst at RUN cycle 17 -> next cycle IDLE with all outputs 0; a fresh start then gives the same signature as an uninterrupted run.
- Start while busy / restart: start pulses during RUN are ignored and completion timing is unchanged. start in DONE -> done=0 next cycle and a repeat run gives an identical signature.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, BIST op table, corner operands, polynomials and FSM states
package alu_pkg;

  // ALU operation codes, shared with the ALU datapath
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Number of operations swept and number of fixed corner vectors per operation
  localparam int N_OPS     = 10;
  localparam int N_CORNERS = 4;

  // Galois LFSR feedback polynomial (shift right, xor when bit 0 falls out)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // MISR feedback taps: bits 31, 21, 1 and 0 feed the new LSB
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } bist_state_t;

  // Sweep order of the operations under test
  function automatic logic [3:0] op_table(input logic [3:0] idx);
    case (idx)
      4'd0:    op_table = ALU_ADD;
      4'd1:    op_table = ALU_SLL;
      4'd2:    op_table = ALU_SLT;
      4'd3:    op_table = ALU_SLTU;
      4'd4:    op_table = ALU_XOR;
      4'd5:    op_table = ALU_SRL;
      4'd6:    op_table = ALU_OR;
      4'd7:    op_table = ALU_AND;
      4'd8:    op_table = ALU_SUB;
      4'd9:    op_table = ALU_SRA;
      default: op_table = ALU_ADD;
    endcase
  endfunction

  // Corner operand A: zero, all-ones, min signed, max signed
  function automatic logic [31:0] corner_a(input logic [1:0] idx);
    case (idx)
      2'd0:    corner_a = 32'h0000_0000;
      2'd1:    corner_a = 32'hFFFF_FFFF;
      2'd2:    corner_a = 32'h8000_0000;
      default: corner_a = 32'h7FFF_FFFF;
    endcase
  endfunction

  // Corner operand B: zero, one, max shift amount, min signed
  function automatic logic [31:0] corner_b(input logic [1:0] idx);
    case (idx)
      2'd0:    corner_b = 32'h0000_0000;
      2'd1:    corner_b = 32'h0000_0001;
      2'd2:    corner_b = 32'h0000_001F;
      default: corner_b = 32'h8000_0000;
    endcase
  endfunction

  // One MISR compaction step: rotate-with-feedback, then fold in the ALU result
  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
    return {m[30:0], ^(m & MISR_TAPS)} ^ d;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// rtl/alu_bist_if.sv - operand/opcode/result bus between the BIST sequencer and the ALU
interface alu_bist_if;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [3:0]  aluOp_out;
  logic [31:0] result_in;

  // The sequencer drives operands and opcode and observes the result
  modport master (
    output a_out,
    output b_out,
    output aluOp_out,
    input  result_in
  );

  // The ALU side consumes operands and opcode and returns the result
  modport slave (
    input  a_out,
    input  b_out,
    input  aluOp_out,
    output result_in
  );
endinterface

// File: rtl/lfsr32.sv
// rtl/lfsr32.sv - 32-bit Galois LFSR with seed load and advance enable
module lfsr32 import alu_pkg::*; #(
  parameter logic [31:0] POLY = LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] next_value
);

  logic [31:0] lfsr_q;

  // The advanced value is exposed so the consumer can use it on the same edge as the advance
  assign next_value = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0000_0000);

  // Seed load has priority over advance; reset clears the register
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (adv) begin
      lfsr_q <= next_value;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - ALU built-in self-test sequencer with MISR signature compaction
module alu_bist import alu_pkg::*; #(
  parameter int          N_VECTORS  = 64,
  parameter logic [31:0] SEED_A     = 32'hACE1_2345,
  parameter logic [31:0] SEED_B     = 32'h1357_9BDF,
  parameter logic [31:0] GOLDEN_SIG = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  alu_bist_if.master       alu,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      signature
);

  localparam logic [15:0] LAST_VEC = 16'(N_VECTORS - 1);
  localparam logic [3:0]  LAST_OP  = 4'(N_OPS - 1);

  bist_state_t state;
  logic [31:0] misr;
  logic [15:0] vec_idx;
  logic [3:0]  op_idx;

  logic        lfsr_load;
  logic        lfsr_adv;
  logic [31:0] lfsr_a_next;
  logic [31:0] lfsr_b_next;

  logic        last_vec;
  logic        last_op;
  logic [15:0] nxt_vec;
  logic [3:0]  nxt_op;
  logic [31:0] nxt_a;
  logic [31:0] nxt_b;
  logic [3:0]  nxt_opcode;
  logic [31:0] misr_nxt;

  // Both generators are seeded together and advance on every RUN edge, never reseeded mid-run
  assign lfsr_load = (state == ST_SEED);
  assign lfsr_adv  = (state == ST_RUN);

  lfsr32 #(.POLY(LFSR_POLY)) u_lfsr_a (
    .clk        (clk),
    .rst        (rst),
    .load       (lfsr_load),
    .seed       (SEED_A),
    .adv        (lfsr_adv),
    .next_value (lfsr_a_next)
  );

  lfsr32 #(.POLY(LFSR_POLY)) u_lfsr_b (
    .clk        (clk),
    .rst        (rst),
    .load       (lfsr_load),
    .seed       (SEED_B),
    .adv        (lfsr_adv),
    .next_value (lfsr_b_next)
  );

  assign misr_nxt  = misr_step(misr, alu.result_in);
  assign signature = misr;

  // Next vector: the first few indices of each op are fixed corners, the rest come from
  // the LFSRs as they stand after this edge's advance
  always_comb begin
    last_vec   = (vec_idx == LAST_VEC);
    last_op    = (op_idx == LAST_OP);
    nxt_vec    = last_vec ? 16'd0 : vec_idx + 16'd1;
    nxt_op     = last_vec ? op_idx + 4'd1 : op_idx;
    nxt_a      = lfsr_a_next;
    nxt_b      = lfsr_b_next;
    if (nxt_vec < 16'(N_CORNERS)) begin
      nxt_a = corner_a(nxt_vec[1:0]);
      nxt_b = corner_b(nxt_vec[1:0]);
    end
    nxt_opcode = op_table(nxt_op);
  end

  // Sequencer FSM with registered ALU drive and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      misr          <= '0;
      vec_idx       <= '0;
      op_idx        <= '0;
      alu.a_out     <= '0;
      alu.b_out     <= '0;
      alu.aluOp_out <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SEED;
            busy  <= 1'b1;
          end
        end

        ST_SEED: begin
          misr          <= '0;
          vec_idx       <= '0;
          op_idx        <= '0;
          alu.a_out     <= corner_a(2'd0);
          alu.b_out     <= corner_b(2'd0);
          alu.aluOp_out <= op_table(4'd0);
          state         <= ST_RUN;
        end

        ST_RUN: begin
          misr    <= misr_nxt;
          vec_idx <= nxt_vec;
          op_idx  <= nxt_op;
          if (last_vec && last_op) begin
            // Final vector absorbed; park the ALU inputs while the signature is judged
            alu.a_out     <= '0;
            alu.b_out     <= '0;
            alu.aluOp_out <= '0;
            state         <= ST_CHECK;
          end else begin
            alu.a_out     <= nxt_a;
            alu.b_out     <= nxt_b;
            alu.aluOp_out <= nxt_opcode;
          end
        end

        ST_CHECK: begin
          alu.a_out     <= '0;
          alu.b_out     <= '0;
          alu.aluOp_out <= '0;
          pass          <= (misr == GOLDEN_SIG);
          busy          <= 1'b0;
          done          <= 1'b1;
          state         <= ST_DONE;
        end

        ST_DONE: begin
          if (start) begin
            done  <= 1'b0;
            pass  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SEED;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// tb/tb_alu_bist.sv - self-checking bench for the ALU BIST sequencer
module tb_alu_bist;

  localparam logic [31:0] SA = 32'hACE1_2345;
  localparam logic [31:0] SB = 32'h1357_9BDF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [3:0] op_of(input int i);
    case (i)
      0: return 4'h0;  1: return 4'h1;  2: return 4'h2;  3: return 4'h3;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'h7;
      8: return 4'h8;  9: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] corner(input int v, input bit is_b);
    case (v)
      0: return 32'h0;
      1: return is_b ? 32'h0000_0001 : 32'hFFFF_FFFF;
      2: return is_b ? 32'h0000_001F : 32'h8000_0000;
      default: return is_b ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a << b[4:0];
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a ^ b;
      4'h5: return a >> b[4:0];
      4'h6: return a | b;
      4'h7: return a & b;
      4'h8: return a - b;
      4'hD: return 32'($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit f);
    return alu_ref(op, a, b) ^ ((f && op == 4'h4) ? 32'd1 : 32'd0);
  endfunction

  function automatic logic [31:0] misr_ref(input logic [31:0] m, input logic [31:0] r);
    return {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ r;
  endfunction

  // Operand of vector t in the whole sweep: corners by position, else LFSR advanced t times
  function automatic logic [31:0] exp_operand(input int n, input logic [31:0] seed, input int t, input bit is_b);
    logic [31:0] x;
    if ((t % n) < 4) return corner(t % n, is_b);
    x = seed;
    for (int i = 0; i < t; i++) x = lfsr_step(x);
    return x;
  endfunction

  function automatic logic [31:0] ref_sig(input int n, input logic [31:0] sa, input logic [31:0] sb, input bit f);
    logic [31:0] m, la, lb, a, b;
    logic [3:0] op;
    m = 0; la = sa; lb = sb;
    for (int t = 0; t < 10 * n; t++) begin
      if (t > 0) begin
        la = lfsr_step(la);
        lb = lfsr_step(lb);
      end
      a  = ((t % n) < 4) ? corner(t % n, 1'b0) : la;
      b  = ((t % n) < 4) ? corner(t % n, 1'b1) : lb;
      op = op_of(t / n);
      m  = misr_ref(m, alu_model(op, a, b, f));
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD4 = ref_sig(4, SA, SB, 1'b0);

  logic clk = 1'b0;
  logic rst, start, sel, fault;
  logic start1, start2;
  logic busy1, done1, pass1, busy2, done2, pass2;
  logic [31:0] sig1, sig2;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_bist_if if1 ();
  alu_bist_if if2 ();

  assign if1.result_in = alu_model(if1.aluOp_out, if1.a_out, if1.b_out, fault);
  assign if2.result_in = alu_model(if2.aluOp_out, if2.a_out, if2.b_out, fault);
  assign start1 = start & ~sel;
  assign start2 = start & sel;

  alu_bist #(.N_VECTORS(4), .SEED_A(SA), .SEED_B(SB), .GOLDEN_SIG(GOLD4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start1), .alu(if1.master),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  alu_bist #(.N_VECTORS(6), .SEED_A(SA), .SEED_B(SB), .GOLDEN_SIG(32'h0)) u_dut6 (
    .clk(clk), .rst(rst), .start(start2), .alu(if2.master),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  logic        m_busy, m_done, m_pass;
  logic [31:0] m_a, m_b, m_sig;
  logic [3:0]  m_op;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_pass = sel ? pass2 : pass1;
  assign m_a    = sel ? if2.a_out : if1.a_out;
  assign m_b    = sel ? if2.b_out : if1.b_out;
  assign m_op   = sel ? if2.aluOp_out : if1.aluOp_out;
  assign m_sig  = sel ? sig2 : sig1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, m_busy, 1'b0);
    check_eq({tag, "_done"}, m_done, 1'b0);
    check_eq({tag, "_pass"}, m_pass, 1'b0);
    check_eq({tag, "_a"}, m_a, 32'h0);
    check_eq({tag, "_b"}, m_b, 32'h0);
    check_eq({tag, "_op"}, m_op, 4'h0);
    check_eq({tag, "_sig"}, m_sig, 32'h0);
  endtask

  task automatic run(input int n, input bit pulses, input bit chk_ops);
    int k;
    int t;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    check_eq("start_busy", m_busy, 1'b1);
    check_eq("start_done", m_done, 1'b0);
    check_eq("start_pass", m_pass, 1'b0);
    while (!m_done && k < 2000) begin
      if (chk_ops && k >= 1 && k <= 10 * n) begin
        t = k - 1;
        check_eq("run_op", m_op, op_of(t / n));
        check_eq("run_a", m_a, exp_operand(n, SA, t, 1'b0));
        check_eq("run_b", m_b, exp_operand(n, SB, t, 1'b1));
      end
      start = pulses && ($urandom_range(0, 2) == 0);
      tick();
      k++;
    end
    start = 1'b0;
    check_eq("latency", k, 2 + 10 * n);
    check_eq("done_busy", m_busy, 1'b0);
    check_eq("done_a", m_a, 32'h0);
    check_eq("done_b", m_b, 32'h0);
    check_eq("done_op", m_op, 4'h0);
  endtask

  task automatic mid_reset(input int at);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrst");
  endtask

  initial begin
    logic [31:0] fsig, sig6;
    sel = 1'b0;
    fault = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check_idle_zero("reset");
    rst = 1'b0;
    tick();
    check_idle_zero("post_reset");

    run(4, 1'b0, 1'b1);
    check_eq("gold_done", m_done, 1'b1);
    check_eq("gold_pass", m_pass, 1'b1);
    check_eq("gold_sig", m_sig, GOLD4);

    repeat ($urandom_range(0, 3)) tick();
    check_eq("held_pass", m_pass, 1'b1);
    run(4, 1'b1, 1'b0);
    check_eq("rerun_pass", m_pass, 1'b1);
    check_eq("rerun_sig", m_sig, GOLD4);

    fault = 1'b1;
    fsig = ref_sig(4, SA, SB, 1'b1);
    run(4, 1'b0, 1'b0);
    fault = 1'b0;
    check_eq("fault_done", m_done, 1'b1);
    check_eq("fault_pass", m_pass, 1'b0);
    check_eq("fault_sig", m_sig, fsig);
    check_eq("fault_differs", (fsig != GOLD4), 1'b1);

    mid_reset(17);
    run(4, 1'b0, 1'b0);
    check_eq("after17_pass", m_pass, 1'b1);
    check_eq("after17_sig", m_sig, GOLD4);

    mid_reset($urandom_range(2, 39));
    run(4, 1'b1, 1'b0);
    check_eq("afterrnd_pass", m_pass, 1'b1);
    check_eq("afterrnd_sig", m_sig, GOLD4);

    sel = 1'b1;
    tick();
    check_idle_zero("n6_idle");
    sig6 = ref_sig(6, SA, SB, 1'b0);
    run(6, 1'b1, 1'b1);
    check_eq("n6_done", m_done, 1'b1);
    check_eq("n6_sig", m_sig, sig6);
    check_eq("n6_pass", m_pass, (sig6 == 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
